// File: rtl/fb_pkg.sv
// Shared geometry defaults, writer state and request layout
// for the framebuffer write engine.
package fb_pkg;

  localparam int FB_CORDW_DEF = 10;
  localparam int FB_W_DEF     = 160;
  localparam int FB_H_DEF     = 120;
  localparam int FB_DW_DEF    = 4;

  typedef enum logic {IDLE, CLEAR} fb_wr_state_t;

  typedef struct packed {
    logic [FB_DW_DEF-1:0]    cidx;
    logic [FB_CORDW_DEF-1:0] y;
    logic [FB_CORDW_DEF-1:0] x;
  } fb_req_t;

endpackage

// File: rtl/fb_writer_fifo.sv
// Single-clock request queue; DEPTH must be a power of two.
// Read data is combinational from the head slot.
module fifo_sync #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             afull_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [AW:0]      cnt_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = cnt_q == (AW+1)'(DEPTH);
  assign afull_o = cnt_q == (AW+1)'(DEPTH-1);
  assign empty_o = cnt_q == '0;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_q];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/fb_writer.sv
// Framebuffer write engine: queued pixel draws plus full clear,
// with BRAM writes gated by the draw window.
module fb_writer
  import fb_pkg::*;
#(
  parameter int CORDW      = FB_CORDW_DEF,
  parameter int FB_WIDTH   = FB_W_DEF,
  parameter int FB_HEIGHT  = FB_H_DEF,
  parameter int FB_DATAW   = FB_DW_DEF,
  parameter int FIFO_DEPTH = 8,
  parameter int FB_ADDRW   = $clog2(FB_WIDTH*FB_HEIGHT)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                draw_en,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [CORDW-1:0]    req_x,
  input  logic [CORDW-1:0]    req_y,
  input  logic [FB_DATAW-1:0] req_cidx,
  input  logic                clear_start,
  input  logic [FB_DATAW-1:0] clear_cidx,
  output logic                busy,
  output logic                clipped,
  output logic                fb_we,
  output logic [FB_ADDRW-1:0] fb_addr_write,
  output logic [FB_DATAW-1:0] fb_cidx_write
);
  localparam int NPIX = FB_WIDTH * FB_HEIGHT;
  localparam int RW   = FB_DATAW + 2 * CORDW;
  localparam logic [FB_ADDRW-1:0] LAST = FB_ADDRW'(NPIX - 1);

  typedef struct packed {
    logic [FB_DATAW-1:0] cidx;
    logic [CORDW-1:0]    y;
    logic [CORDW-1:0]    x;
  } req_t;

  fb_wr_state_t        state_q;
  logic                pend_q;
  logic [FB_DATAW-1:0] ccol_q;
  logic [FB_ADDRW-1:0] cnt_q;
  logic                ready_q;
  logic                clip_q;
  logic                s1_vld_q;
  logic [FB_ADDRW-1:0] s1_addr_q;
  logic [FB_DATAW-1:0] s1_cidx_q;
  logic                we_q;
  logic [FB_ADDRW-1:0] addr_q;
  logic [FB_DATAW-1:0] cidx_q;

  logic                xfer;
  logic                oob;
  logic                push;
  logic                pop;
  logic                full;
  logic                afull;
  logic                empty;
  req_t                wreq;
  req_t                rreq;
  logic [FB_ADDRW-1:0] addr_d;
  logic [RW-1:0]       rdata;

  assign xfer   = req_valid && ready_q;
  assign oob    = (int'(req_x) >= FB_WIDTH) ||
                  (int'(req_y) >= FB_HEIGHT);
  assign push   = xfer && !oob;
  // a pending clear blocks pops so stage 1 drains
  assign pop    = draw_en && !empty &&
                  (state_q == IDLE) && !pend_q;
  assign wreq   = '{cidx: req_cidx, y: req_y, x: req_x};
  assign rreq   = req_t'(rdata);
  assign addr_d = FB_ADDRW'(rreq.y) * FB_ADDRW'(FB_WIDTH)
                + FB_ADDRW'(rreq.x);

  fifo_sync #(
    .WIDTH (RW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (wreq),
    .pop_i   (pop),
    .rdata_o (rdata),
    .full_o  (full),
    .empty_o (empty),
    .afull_o (afull)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pend_q    <= 1'b0;
      ccol_q    <= '0;
      cnt_q     <= '0;
      ready_q   <= 1'b0;
      clip_q    <= 1'b0;
      s1_vld_q  <= 1'b0;
      s1_addr_q <= '0;
      s1_cidx_q <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      cidx_q    <= '0;
    end else begin
      ready_q <= !(full || (afull && push));
      clip_q  <= xfer && oob;
      if (draw_en) begin
        s1_vld_q <= pop;
        if (pop) begin
          s1_addr_q <= addr_d;
          s1_cidx_q <= rreq.cidx;
        end
      end
      unique case (state_q)
        IDLE: begin
          we_q <= draw_en && s1_vld_q;
          if (draw_en && s1_vld_q) begin
            addr_q <= s1_addr_q;
            cidx_q <= s1_cidx_q;
          end
          if (pend_q && !s1_vld_q) begin
            state_q <= CLEAR;
          end else if (clear_start && !pend_q) begin
            pend_q <= 1'b1;
            ccol_q <= clear_cidx;
          end
        end
        CLEAR: begin
          we_q <= draw_en;
          if (draw_en) begin
            addr_q <= cnt_q;
            cidx_q <= ccol_q;
            if (cnt_q == LAST) begin
              cnt_q   <= '0;
              pend_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready     = ready_q;
  assign clipped       = clip_q;
  assign fb_we         = we_q;
  assign fb_addr_write = addr_q;
  assign fb_cidx_write = cidx_q;
  assign busy = (state_q != IDLE) || pend_q || !empty ||
                s1_vld_q || we_q;

endmodule

// File: tb/tb_fb_writer.sv
// Randomized self-checking bench for fb_writer against a
// queue-based model of the expected BRAM write stream.
module tb_fb_writer;

  localparam int W = 160;
  localparam int H = 120;
  localparam int NPIX = W * H;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        draw_en = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [9:0]  req_x = '0;
  logic [9:0]  req_y = '0;
  logic [3:0]  req_cidx = '0;
  logic        clear_start = 1'b0;
  logic [3:0]  clear_cidx = '0;
  logic        busy;
  logic        clipped;
  logic        fb_we;
  logic [14:0] fb_addr_write;
  logic [3:0]  fb_cidx_write;

  int checks = 0;
  int failures = 0;

  logic [18:0] obs_q[$];
  int          obs_cyc[$];
  logic [18:0] exp_q[$];
  int          bad_we = 0;
  int          clip_cnt = 0;
  int          cyc = 0;

  fb_writer dut (
    .clk           (clk),
    .rst           (rst),
    .draw_en       (draw_en),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_x         (req_x),
    .req_y         (req_y),
    .req_cidx      (req_cidx),
    .clear_start   (clear_start),
    .clear_cidx    (clear_cidx),
    .busy          (busy),
    .clipped       (clipped),
    .fb_we         (fb_we),
    .fb_addr_write (fb_addr_write),
    .fb_cidx_write (fb_cidx_write)
  );

  always #5 clk = ~clk;

  // observe the write port one time unit after each edge
  always @(posedge clk) begin
    logic de;
    de = draw_en;
    cyc++;
    #1;
    if (fb_we) begin
      obs_q.push_back({fb_addr_write, fb_cidx_write});
      obs_cyc.push_back(cyc);
      if (!de) bad_we++;
    end
    if (clipped) clip_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [18:0] ent(int x, int y, logic [3:0] c);
    return {15'(y * W + x), c};
  endfunction

  task automatic wait_idle(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      tick();
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic send(input int x, input int y,
                      input logic [3:0] c, output bit ok);
    logic acc;
    req_valid = 1'b1;
    req_x = 10'(x);
    req_y = 10'(y);
    req_cidx = c;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      acc = req_ready;
      tick();
      if (acc) begin
        ok = 1'b1;
        break;
      end
    end
    req_valid = 1'b0;
    if (ok && x < W && y < H) exp_q.push_back(ent(x, y, c));
  endtask

  task automatic cmp(input string nm, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic cmp_stream(input string nm);
    cmp({nm, "_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL %s[%0d] actual=%h required=%h",
                 nm, i, obs_q[i], exp_q[i]);
        break;
      end
    end
  endtask

  task automatic clear_sb();
    obs_q.delete();
    obs_cyc.delete();
    exp_q.delete();
    bad_we = 0;
    clip_cnt = 0;
  endtask

  task automatic test_reset();
    tick();
    tick();
    cmp("rst_we", int'(fb_we), 0);
    cmp("rst_addr", int'(fb_addr_write), 0);
    cmp("rst_cidx", int'(fb_cidx_write), 0);
    cmp("rst_busy", int'(busy), 0);
    cmp("rst_clipped", int'(clipped), 0);
    cmp("rst_ready", int'(req_ready), 0);
    rst = 1'b0;
    #1;
    cmp("ready_before_edge", int'(req_ready), 0);
    tick();
    cmp("ready_after_edge", int'(req_ready), 1);
  endtask

  task automatic test_single();
    clear_sb();
    draw_en = 1'b1;
    req_valid = 1'b1;
    req_x = 10'd3;
    req_y = 10'd2;
    req_cidx = 4'd5;
    tick();
    req_valid = 1'b0;
    cmp("lat_k", int'(fb_we), 0);
    tick();
    cmp("lat_k1", int'(fb_we), 0);
    tick();
    cmp("lat_k2_we", int'(fb_we), 1);
    cmp("lat_k2_addr", int'(fb_addr_write), 323);
    cmp("lat_k2_data", int'(fb_cidx_write), 5);
    cmp("lat_k2_busy", int'(busy), 1);
    tick();
    cmp("lat_k3_we", int'(fb_we), 0);
    cmp("lat_k3_busy", int'(busy), 0);
    cmp("hold_addr", int'(fb_addr_write), 323);
  endtask

  task automatic test_back_to_back();
    int acc_n;
    logic acc;
    logic [3:0] c;
    int x;
    int y;
    bit ok;
    clear_sb();
    draw_en = 1'b0;
    acc_n = 0;
    for (int i = 0; i < 10; i++) begin
      x = $urandom_range(W - 1);
      y = $urandom_range(H - 1);
      c = 4'($urandom);
      req_valid = 1'b1;
      req_x = 10'(x);
      req_y = 10'(y);
      req_cidx = c;
      acc = req_ready;
      tick();
      if (acc) begin
        acc_n++;
        exp_q.push_back(ent(x, y, c));
      end
    end
    req_valid = 1'b0;
    tick();
    cmp("bp_accepted", acc_n, 8);
    cmp("bp_ready_low", int'(req_ready), 0);
    cmp("bp_no_write", obs_q.size(), 0);
    draw_en = 1'b1;
    wait_idle(40, ok);
    cmp("bp_idle", int'(ok), 1);
    cmp_stream("bp_stream");
    if (obs_cyc.size() == 8)
      cmp("bp_consecutive", obs_cyc[7] - obs_cyc[0], 7);
    else
      cmp("bp_consecutive", obs_cyc.size(), 8);
    cmp("bp_ready_back", int'(req_ready), 1);
  endtask

  task automatic test_clip();
    bit ok;
    clear_sb();
    draw_en = 1'b1;
    send(W, 0, 4'($urandom), ok);
    send(0, H, 4'($urandom), ok);
    send(W - 1, H - 1, 4'($urandom), ok);
    send($urandom_range(1023, W), $urandom_range(H - 1),
         4'($urandom), ok);
    send(0, 0, 4'($urandom), ok);
    wait_idle(40, ok);
    cmp("clip_idle", int'(ok), 1);
    cmp("clip_pulses", clip_cnt, 3);
    cmp_stream("clip_stream");
  endtask

  task automatic test_clear();
    bit ok;
    int errs;
    clear_sb();
    draw_en = 1'b1;
    clear_start = 1'b1;
    clear_cidx = 4'hF;
    tick();
    clear_start = 1'b0;
    wait_idle(NPIX + 200, ok);
    cmp("clr_idle", int'(ok), 1);
    cmp("clr_count", obs_q.size(), NPIX);
    errs = 0;
    for (int i = 0; i < obs_q.size(); i++)
      if (obs_q[i] !== ent(i % W, i / W, 4'hF)) errs++;
    cmp("clr_seq_errors", errs, 0);
    cmp("clr_busy", int'(busy), 0);
  endtask

  task automatic test_clear_stall();
    logic [3:0] cc;
    logic [3:0] dc[3];
    int dx[3];
    int dy[3];
    int sent;
    int errs;
    logic acc;
    bit ok;
    clear_sb();
    cc = 4'($urandom);
    for (int i = 0; i < 3; i++) begin
      dx[i] = $urandom_range(W - 1);
      dy[i] = $urandom_range(H - 1);
      dc[i] = 4'($urandom);
    end
    draw_en = 1'b1;
    clear_start = 1'b1;
    clear_cidx = cc;
    tick();
    clear_start = 1'b0;
    sent = 0;
    for (int c = 0; c < 40000 && obs_q.size() < NPIX + 3; c++) begin
      if (obs_q.size() < 200 || obs_q.size() > NPIX - 50)
        draw_en = (c % 4 == 0);
      else
        draw_en = 1'b1;
      req_valid = sent < 3;
      if (sent < 3) begin
        req_x = 10'(dx[sent]);
        req_y = 10'(dy[sent]);
        req_cidx = dc[sent];
      end
      clear_start = (c == 500);
      clear_cidx = ~cc;
      acc = req_valid && req_ready;
      tick();
      if (acc) sent++;
    end
    req_valid = 1'b0;
    clear_start = 1'b0;
    draw_en = 1'b1;
    wait_idle(40, ok);
    cmp("stall_idle", int'(ok), 1);
    cmp("stall_count", obs_q.size(), NPIX + 3);
    errs = 0;
    for (int i = 0; i < NPIX && i < obs_q.size(); i++)
      if (obs_q[i] !== ent(i % W, i / W, cc)) errs++;
    for (int i = 0; i < 3 && NPIX + i < obs_q.size(); i++)
      if (obs_q[NPIX + i] !== ent(dx[i], dy[i], dc[i])) errs++;
    cmp("stall_seq_errors", errs, 0);
    cmp("stall_outside_window", bad_we, 0);
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_sb();
    draw_en = 1'b1;
    clear_start = 1'b1;
    clear_cidx = 4'($urandom);
    tick();
    clear_start = 1'b0;
    for (int i = 0; i < 4; i++)
      send($urandom_range(W - 1), $urandom_range(H - 1),
           4'($urandom), ok);
    for (int i = 0; i < 50; i++) tick();
    cmp("mid_we_before", int'(fb_we), 1);
    rst = 1'b1;
    #1;
    cmp("mid_we_async", int'(fb_we), 0);
    tick();
    tick();
    rst = 1'b0;
    obs_q.delete();
    for (int i = 0; i < 30; i++) tick();
    cmp("mid_no_writes", obs_q.size(), 0);
    cmp("mid_busy", int'(busy), 0);
    cmp("mid_ready", int'(req_ready), 1);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_clip();
    test_clear();
    test_clear_stall();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
